// File: rtl/conway_pkg.sv
// Shared constants and padding mask for the Conway window generator and evaluator.
// Neighbour bit positions are common to both blocks.
package conway_pkg;

  localparam int NB_NW        = 0;
  localparam int NB_N         = 1;
  localparam int NB_NE        = 2;
  localparam int NB_W         = 3;
  localparam int NB_E         = 4;
  localparam int NB_SW        = 5;
  localparam int NB_S         = 6;
  localparam int NB_SE        = 7;
  localparam int NB_C         = 8;
  localparam int CONWAY_WIN_W = 9;

  typedef logic [CONWAY_WIN_W-1:0] conway_win_t;

  // Zero the neighbours that fall outside the grid.
  function automatic conway_win_t conway_mask(
    input conway_win_t win,
    input logic        at_l,
    input logic        at_r,
    input logic        at_t,
    input logic        at_b
  );
    conway_win_t m;
    m = win;
    if (at_l) begin
      m[NB_NW] = 1'b0;
      m[NB_W]  = 1'b0;
      m[NB_SW] = 1'b0;
    end
    if (at_r) begin
      m[NB_NE] = 1'b0;
      m[NB_E]  = 1'b0;
      m[NB_SE] = 1'b0;
    end
    if (at_t) begin
      m[NB_NW] = 1'b0;
      m[NB_N]  = 1'b0;
      m[NB_NE] = 1'b0;
    end
    if (at_b) begin
      m[NB_SW] = 1'b0;
      m[NB_S]  = 1'b0;
      m[NB_SE] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/conway_window_gen.sv
// Raster cell stream to 3x3 neighbourhood windows, zero padded at grid edges.
// One window per cell; the last WIDTH+1 windows are flushed with in_ready low.
module conway_window_gen
  import conway_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_cell,
  output logic                    out_valid,
  output logic [CONWAY_WIN_W-1:0] out_cells,
  output logic [XW-1:0]           out_x,
  output logic [YW-1:0]           out_y,
  output logic                    out_last,
  output logic                    busy
);

  localparam int N   = WIDTH * HEIGHT;
  localparam int SRW = 2 * WIDTH + 3;
  localparam int CW  = $clog2(N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  cx_q, cx_d, ox_q;
  logic [YW-1:0]  cy_q, cy_d, oy_q;
  conway_win_t    win, cells_q;
  logic           ov_q, olast_q;
  logic           xfer, flush, shift, emit;
  logic           at_l, at_r, at_t, at_b, at_end;
  logic           unused_sr_msb;

  assign flush    = (state_q == S_FLUSH);
  assign in_ready = !flush;
  assign xfer     = in_valid & in_ready;
  assign shift    = xfer | flush;
  assign sr_d     = shift ? {sr_q[SRW-2:0], xfer & in_cell} : sr_q;

  // Oldest bit is only needed by the window built from sr_d.
  assign unused_sr_msb = sr_q[SRW-1];

  assign emit = flush
              | (xfer && state_q == S_STREAM
                 && cnt_q >= CW'(WIDTH + 1));

  assign at_l   = (cx_q == '0);
  assign at_r   = (cx_q == XW'(WIDTH - 1));
  assign at_t   = (cy_q == '0);
  assign at_b   = (cy_q == YW'(HEIGHT - 1));
  assign at_end = at_r & at_b;

  // sr_d[0] is the newest cell; the centre sits WIDTH+1 behind it.
  always_comb begin
    win        = '0;
    win[NB_NW] = sr_d[2*WIDTH+2];
    win[NB_N]  = sr_d[2*WIDTH+1];
    win[NB_NE] = sr_d[2*WIDTH];
    win[NB_W]  = sr_d[WIDTH+2];
    win[NB_C]  = sr_d[WIDTH+1];
    win[NB_E]  = sr_d[WIDTH];
    win[NB_SW] = sr_d[2];
    win[NB_S]  = sr_d[1];
    win[NB_SE] = sr_d[0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_STREAM;
          cnt_d   = CW'(1);
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (at_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (emit) begin
      if (at_r) begin
        cx_d = '0;
        cy_d = at_b ? '0 : cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      cells_q <= '0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ov_q    <= emit;
      olast_q <= emit & at_end;
      if (emit) begin
        cells_q <= conway_mask(win, at_l, at_r, at_t, at_b);
        ox_q    <= cx_q;
        oy_q    <= cy_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_cells = cells_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_last  = olast_q;
  assign busy      = (state_q != S_IDLE);

endmodule
